control_sequencer: RTL and testbench

- Hardwired control unit that drives the single-bus datapath's strobe inputs through fetch and execute.
- It is the sequencing end of the datapath control interface: it reads the instruction register and emits, each T-state, the out/in/ALU strobes that benches currently drive by hand.
- Covers the register-register ALU ops, neg/not, mul/div (HI/LO), nop and halt.
- Memory reads use a Read/Mem_ready handshake.

---
 rtl/control_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus datapath.
// Emits per-T-state bus, load and register-select strobes from the IR.
module control_sequencer #(
    parameter logic [4:0] HALT_OP = 5'b11011,
    parameter logic [4:0] NOP_OP  = 5'b11010,
    parameter logic [4:0] MUL_OP  = 5'b01111,
    parameter logic [4:0] DIV_OP  = 5'b10000,
    parameter logic [4:0] NEG_OP  = 5'b10001,
    parameter logic [4:0] NOT_OP  = 5'b10010
) (
    input  logic        Clock,
    input  logic        Clear_n,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic zhi_out;
        logic mdr_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } ctl_t;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    logic       illegal_d;
    ctl_t       ctl;
    logic [4:0] alu_d;

    logic [4:0] op;
    logic       op_alu;
    logic       op_hilo;
    logic       op_unary;
    logic       op_exec;
    logic       op_nop;
    logic       op_halt;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign op_alu   = (op <= 5'b01110);
    assign op_hilo  = (op == MUL_OP) || (op == DIV_OP);
    assign op_unary = (op == NEG_OP) || (op == NOT_OP);
    assign op_exec  = op_alu || op_hilo || op_unary;
    assign op_nop   = (op == NOP_OP);
    assign op_halt  = (op == HALT_OP);

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q   <= S_T0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        unique case (state_q)
            S_T0: state_d = S_T1;
            S_T1: begin
                if (Mem_ready) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                unique case (1'b1)
                    op_halt: state_d = S_HALT;
                    op_nop:  state_d = S_T0;
                    op_exec: state_d = S_T3;
                    default: begin
                        state_d   = S_T0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = op_unary ? S_T0 : S_T5;
            S_T5: state_d = op_hilo ? S_T6 : S_T0;
            S_T6: state_d = S_T0;
            S_HALT: state_d = S_HALT;
        endcase
    end

    // Execute-phase strobes depend on the opcode class latched in IR at T2.
    always_comb begin
        ctl   = '0;
        alu_d = 5'b00000;
        unique case (state_q)
            S_T0: begin
                ctl.pc_out = 1'b1;
                ctl.mar_in = 1'b1;
                ctl.inc_pc = 1'b1;
                ctl.z_in   = 1'b1;
            end
            S_T1: begin
                ctl.zlo_out = 1'b1;
                ctl.pc_in   = 1'b1;
                ctl.read    = 1'b1;
                ctl.mdr_in  = 1'b1;
            end
            S_T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            S_T3: begin
                ctl.r_out = 1'b1;
                unique case (1'b1)
                    op_hilo: begin
                        ctl.gra  = 1'b1;
                        ctl.y_in = 1'b1;
                    end
                    op_unary: begin
                        ctl.grb  = 1'b1;
                        ctl.z_in = 1'b1;
                        alu_d    = op;
                    end
                    default: begin
                        ctl.grb  = 1'b1;
                        ctl.y_in = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    op_unary: begin
                        ctl.zlo_out = 1'b1;
                        ctl.gra     = 1'b1;
                        ctl.r_in    = 1'b1;
                    end
                    op_hilo: begin
                        ctl.grb   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.z_in  = 1'b1;
                        alu_d     = op;
                    end
                    default: begin
                        ctl.grc   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.z_in  = 1'b1;
                        alu_d     = op;
                    end
                endcase
            end
            S_T5: begin
                ctl.zlo_out = 1'b1;
                if (op_hilo) begin
                    ctl.lo_in = 1'b1;
                end else begin
                    ctl.gra  = 1'b1;
                    ctl.r_in = 1'b1;
                end
            end
            S_T6: begin
                ctl.zhi_out = 1'b1;
                ctl.hi_in   = 1'b1;
            end
            S_HALT: ;
        endcase
    end

    // Outputs are masked while Clear_n is low so a mid-instruction
    // reset never shows the T0 strobes before release.
    assign PCout    = Clear_n & ctl.pc_out;
    assign Zlowout  = Clear_n & ctl.zlo_out;
    assign Zhighout = Clear_n & ctl.zhi_out;
    assign MDRout   = Clear_n & ctl.mdr_out;
    assign PCin     = Clear_n & ctl.pc_in;
    assign MARin    = Clear_n & ctl.mar_in;
    assign MDRin    = Clear_n & ctl.mdr_in;
    assign IRin     = Clear_n & ctl.ir_in;
    assign Yin      = Clear_n & ctl.y_in;
    assign Zin      = Clear_n & ctl.z_in;
    assign HIin     = Clear_n & ctl.hi_in;
    assign LOin     = Clear_n & ctl.lo_in;
    assign IncPC    = Clear_n & ctl.inc_pc;
    assign Read     = Clear_n & ctl.read;
    assign Gra      = Clear_n & ctl.gra;
    assign Grb      = Clear_n & ctl.grb;
    assign Grc      = Clear_n & ctl.grc;
    assign Rin      = Clear_n & ctl.r_in;
    assign Rout     = Clear_n & ctl.r_out;
    assign alu_op   = Clear_n ? alu_d : 5'b00000;
    assign Illegal  = Clear_n & illegal_q;
    assign Run      = !Clear_n || (state_q != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: cycle-by-cycle strobe vectors checked
// through a scoreboard queue, plus an asynchronous mid-instruction reset.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear_n = 1'b0;
    logic [31:0] IR = 32'h20918000;
    logic        Mem_ready = 1'b1;
    logic PCout, Zlowout, Zhighout, MDRout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
    logic [4:0] alu_op;

    control_sequencer dut (
        .Clock(Clock), .Clear_n(Clear_n), .IR(IR), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run),
        .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    localparam logic [20:0] PCO  = 21'd1 << 0;
    localparam logic [20:0] ZLO  = 21'd1 << 1;
    localparam logic [20:0] ZHO  = 21'd1 << 2;
    localparam logic [20:0] MDRO = 21'd1 << 3;
    localparam logic [20:0] PCI  = 21'd1 << 4;
    localparam logic [20:0] MARI = 21'd1 << 5;
    localparam logic [20:0] MDRI = 21'd1 << 6;
    localparam logic [20:0] IRI  = 21'd1 << 7;
    localparam logic [20:0] YI   = 21'd1 << 8;
    localparam logic [20:0] ZI   = 21'd1 << 9;
    localparam logic [20:0] HII  = 21'd1 << 10;
    localparam logic [20:0] LOI  = 21'd1 << 11;
    localparam logic [20:0] INC  = 21'd1 << 12;
    localparam logic [20:0] RD   = 21'd1 << 13;
    localparam logic [20:0] GRA  = 21'd1 << 14;
    localparam logic [20:0] GRB  = 21'd1 << 15;
    localparam logic [20:0] GRC  = 21'd1 << 16;
    localparam logic [20:0] RI   = 21'd1 << 17;
    localparam logic [20:0] RO   = 21'd1 << 18;
    localparam logic [20:0] RUN  = 21'd1 << 19;
    localparam logic [20:0] ILL  = 21'd1 << 20;

    localparam logic [20:0] RST = RUN;
    localparam logic [20:0] T0E = PCO | MARI | INC | ZI | RUN;
    localparam logic [20:0] T1E = ZLO | PCI | RD | MDRI | RUN;
    localparam logic [20:0] T2E = MDRO | IRI | RUN;
    localparam logic [20:0] A3  = GRB | RO | YI | RUN;
    localparam logic [20:0] A4  = GRC | RO | ZI | RUN;
    localparam logic [20:0] A5  = ZLO | GRA | RI | RUN;
    localparam logic [20:0] M3  = GRA | RO | YI | RUN;
    localparam logic [20:0] M4  = GRB | RO | ZI | RUN;
    localparam logic [20:0] M5  = ZLO | LOI | RUN;
    localparam logic [20:0] M6  = ZHO | HII | RUN;
    localparam logic [20:0] N3  = GRB | RO | ZI | RUN;
    localparam logic [20:0] N4  = ZLO | GRA | RI | RUN;
    localparam logic [20:0] HLT = 21'd0;

    localparam logic [31:0] I_SUB  = 32'h20918000;
    localparam logic [31:0] I_ADD  = 32'h18918000;
    localparam logic [31:0] I_A14  = 32'h70918000;
    localparam logic [31:0] I_MUL  = 32'h78918000;
    localparam logic [31:0] I_DIV  = 32'h80918000;
    localparam logic [31:0] I_NEG  = 32'h88918000;
    localparam logic [31:0] I_NOT  = 32'h90918000;
    localparam logic [31:0] I_U19  = 32'h98918000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_U31  = 32'hF8000000;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        mr;
        logic [20:0] exp;
        logic [4:0]  alu;
        string       name;
    } vec_t;

    typedef struct {
        logic [20:0] exp;
        logic [4:0]  alu;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic logic [20:0] act_bits();
        return {Illegal, Run, Rout, Rin, Grc, Grb, Gra, Read, IncPC,
                LOin, HIin, Zin, Yin, IRin, MDRin, MARin, PCin,
                MDRout, Zhighout, Zlowout, PCout};
    endfunction

    task automatic check(string nm, logic [20:0] e, logic [4:0] ea);
        n_tests++;
        if (act_bits() !== e || alu_op !== ea) begin
            n_fail++;
            $display("FAIL %s: got strobes=%h alu_op=%b, expected strobes=%h alu_op=%b",
                     nm, act_bits(), alu_op, e, ea);
        end
    endtask

    function automatic void add(logic clr, logic [31:0] ir, logic mr,
                                logic [20:0] e, logic [4:0] a, string nm);
        vec_t v;
        v.clr = clr; v.ir = ir; v.mr = mr;
        v.exp = e; v.alu = a; v.name = nm;
        vecs.push_back(v);
    endfunction

    function automatic void fetch(logic [31:0] ir, string nm, logic ill);
        add(1'b1, ir, 1'b1, ill ? (T0E | ILL) : T0E, 5'b0, {nm, "_t0"});
        add(1'b1, ir, 1'b1, T1E, 5'b0, {nm, "_t1"});
        add(1'b1, ir, 1'b1, T2E, 5'b0, {nm, "_t2"});
    endfunction

    task automatic apply(vec_t v);
        sb_t s;
        @(posedge Clock);
        #1;
        Clear_n   = v.clr;
        IR        = v.ir;
        Mem_ready = v.mr;
        s.exp = v.exp; s.alu = v.alu; s.name = v.name;
        sb.push_back(s);
    endtask

    always @(negedge Clock) begin
        sb_t s;
        if (sb.size() > 0) begin
            s = sb.pop_front();
            check(s.name, s.exp, s.alu);
        end
    end

    // One bus driver at most, and exactly one register select during Rin/Rout.
    always @(negedge Clock) begin
        n_tests++;
        if ($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) > 1) begin
            n_fail++;
            $display("FAIL bus_contention: got drivers=%b, expected at most one",
                     {PCout, Zlowout, Zhighout, MDRout, Rout});
        end
        if (Rin || Rout) begin
            n_tests++;
            if ($countones({Gra, Grb, Grc}) != 1) begin
                n_fail++;
                $display("FAIL reg_select: got Gra/Grb/Grc=%b, expected one-hot",
                         {Gra, Grb, Grc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        add(1'b0, I_SUB, 1'b1, RST, 5'b0, "reset");
        fetch(I_SUB, "sub", 1'b0);
        add(1'b1, I_SUB, 1'b1, A3, 5'b0, "sub_t3");
        add(1'b1, I_SUB, 1'b1, A4, 5'b00100, "sub_t4");
        add(1'b1, I_SUB, 1'b1, A5, 5'b0, "sub_t5");

        add(1'b1, I_SUB, 1'b1, T0E, 5'b0, "wait_t0");
        for (int i = 0; i < 3; i++)
            add(1'b1, I_SUB, 1'b0, T1E, 5'b0, "wait_t1_stall");
        add(1'b1, I_SUB, 1'b1, T1E, 5'b0, "wait_t1_ready");
        add(1'b1, I_SUB, 1'b1, T2E, 5'b0, "wait_t2");
        add(1'b1, I_SUB, 1'b1, A3, 5'b0, "wait_t3");
        add(1'b1, I_SUB, 1'b1, A4, 5'b00100, "wait_t4");
        add(1'b1, I_SUB, 1'b1, A5, 5'b0, "wait_t5");

        fetch(I_MUL, "mul", 1'b0);
        add(1'b1, I_MUL, 1'b1, M3, 5'b0, "mul_t3");
        add(1'b1, I_MUL, 1'b1, M4, 5'b01111, "mul_t4");
        add(1'b1, I_MUL, 1'b1, M5, 5'b0, "mul_t5");
        add(1'b1, I_MUL, 1'b1, M6, 5'b0, "mul_t6");

        fetch(I_DIV, "div", 1'b0);
        add(1'b1, I_DIV, 1'b1, M3, 5'b0, "div_t3");
        add(1'b1, I_DIV, 1'b1, M4, 5'b10000, "div_t4");
        add(1'b1, I_DIV, 1'b1, M5, 5'b0, "div_t5");
        add(1'b1, I_DIV, 1'b1, M6, 5'b0, "div_t6");

        fetch(I_NEG, "neg", 1'b0);
        add(1'b1, I_NEG, 1'b1, N3, 5'b10001, "neg_t3");
        add(1'b1, I_NEG, 1'b1, N4, 5'b0, "neg_t4");

        fetch(I_NOT, "not", 1'b0);
        add(1'b1, I_NOT, 1'b1, N3, 5'b10010, "not_t3");
        add(1'b1, I_NOT, 1'b1, N4, 5'b0, "not_t4");

        fetch(I_A14, "op14", 1'b0);
        add(1'b1, I_A14, 1'b1, A3, 5'b0, "op14_t3");
        add(1'b1, I_A14, 1'b1, A4, 5'b01110, "op14_t4");
        add(1'b1, I_A14, 1'b1, A5, 5'b0, "op14_t5");

        fetch(I_NOP, "nop", 1'b0);
        fetch(I_U19, "ill19", 1'b0);
        fetch(I_U31, "ill31", 1'b1);
        fetch(I_SUB, "after_ill", 1'b1);
        add(1'b1, I_SUB, 1'b1, A3, 5'b0, "after_ill_t3");
        add(1'b1, I_SUB, 1'b1, A4, 5'b00100, "after_ill_t4");
        add(1'b1, I_SUB, 1'b1, A5, 5'b0, "after_ill_t5");

        fetch(I_HALT, "halt", 1'b0);
        for (int i = 0; i < 20; i++)
            add(1'b1, I_HALT, 1'b1, HLT, 5'b0, "halt_hold");
        add(1'b0, I_HALT, 1'b1, RST, 5'b0, "halt_clear");
        fetch(I_ADD, "post_halt", 1'b0);
        add(1'b1, I_ADD, 1'b1, A3, 5'b0, "post_halt_t3");

        foreach (vecs[i]) apply(vecs[i]);

        v.clr = 1'b1; v.ir = I_ADD; v.mr = 1'b1;
        v.exp = A4; v.alu = 5'b00011; v.name = "async_t4";
        apply(v);
        @(negedge Clock);
        #2;
        Clear_n = 1'b0;
        #1;
        check("async_clear_now", RST, 5'b0);
        v.clr = 1'b1; v.exp = T0E; v.alu = 5'b0; v.name = "async_release_t0";
        apply(v);
        v.exp = T1E; v.name = "async_release_t1";
        apply(v);
        v.exp = T2E; v.name = "async_release_t2";
        apply(v);

        @(negedge Clock);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
